// File: rtl/inst_loader.sv
// inst_loader: byte-stream program loader and run controller for the 9-bit core.
// Stream: count[7:0], count[15:8], then N pairs of {instr[7:0]}, {7'bx, instr[8]}.
// Words are written to instruction memory from address 0 upward. The core is held
// in init (cpu_start=1) until BOOT_CYC cycles after the final write. RUN length is
// then measured until cpu_halt.
module inst_loader #(
  parameter int AW       = 10,
  parameter int BOOT_CYC = 2
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          inst_wr_en,
  output logic [AW-1:0] inst_wr_addr,
  output logic [8:0]    inst_wr_data,
  output logic          cpu_start,
  input  logic          cpu_halt,
  output logic          done,
  output logic          err,
  output logic [15:0]   run_cycles
);

  localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, CNT_HI, INS_LO, INS_HI, BOOT, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   cnt;        // instruction count N
  logic [AW:0]   idx;        // one extra bit so N = 2^AW is representable
  logic [7:0]    ins_lo;
  logic [BW-1:0] boot_cnt;
  logic [15:0]   hdr_n;
  logic          hdr_bad;
  logic          last_word;
  logic          acc;

  assign acc       = in_valid & in_ready;
  assign hdr_n     = {in_data, cnt[7:0]};
  assign hdr_bad   = (hdr_n == 16'd0) || (32'(hdr_n) > (32'd1 << AW));
  assign last_word = ((32'(idx) + 32'd1) == 32'(cnt));
  assign done      = (state == DONE);

  // State register; reset drops straight back to IDLE (cpu_start rises with it)
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake/init outputs, decoded from the current state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        cpu_start = 1'b1;
        if (in_valid) state_nxt = CNT_HI;
      end
      CNT_HI: begin
        in_ready  = 1'b1;
        cpu_start = 1'b1;
        if (in_valid) state_nxt = hdr_bad ? IDLE : INS_LO;
      end
      INS_LO: begin
        in_ready  = 1'b1;
        cpu_start = 1'b1;
        if (in_valid) state_nxt = INS_HI;
      end
      INS_HI: begin
        in_ready  = 1'b1;
        cpu_start = 1'b1;
        if (in_valid) state_nxt = last_word ? BOOT : INS_LO;
      end
      BOOT: begin
        cpu_start = 1'b1;
        if (boot_cnt == '0) state_nxt = RUN;
      end
      RUN: begin
        // halt is only honoured here; earlier it may be stale from a previous run
        if (cpu_halt) state_nxt = DONE;
      end
      DONE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CNT_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: header latch, word assembly, write strobe, boot countdown, run counter
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      ins_lo       <= '0;
      boot_cnt     <= '0;
      inst_wr_en   <= 1'b0;
      inst_wr_addr <= '0;
      inst_wr_data <= '0;
      err          <= 1'b0;
      run_cycles   <= '0;
    end else begin
      inst_wr_en <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE, DONE: if (acc) cnt[7:0] <= in_data;
        CNT_HI: if (acc) begin
          if (hdr_bad) err <= 1'b1;
          else begin
            cnt        <= hdr_n;
            idx        <= '0;
            run_cycles <= '0;
          end
        end
        INS_LO: if (acc) ins_lo <= in_data;
        INS_HI: if (acc) begin
          inst_wr_en   <= 1'b1;
          inst_wr_addr <= idx[AW-1:0];
          inst_wr_data <= {in_data[0], ins_lo};
          idx          <= idx + 1'b1;
          // BOOT begins in the cycle this write is presented, so it counts toward BOOT_CYC
          boot_cnt     <= BW'(BOOT_CYC - 1);
        end
        BOOT: if (boot_cnt != '0) boot_cnt <= boot_cnt - 1'b1;
        RUN: if (!cpu_halt && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: scoreboard of expected memory writes
// plus directed checks of handshake, boot window, run counter and error paths.
module tb_inst_loader;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          inst_wr_en;
  logic [AW-1:0] inst_wr_addr;
  logic [8:0]    inst_wr_data;
  logic          cpu_start;
  logic          cpu_halt;
  logic          done;
  logic          err;
  logic [15:0]   run_cycles;

  inst_loader #(.AW(AW), .BOOT_CYC(2)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .inst_wr_en(inst_wr_en), .inst_wr_addr(inst_wr_addr),
    .inst_wr_data(inst_wr_data), .cpu_start(cpu_start), .cpu_halt(cpu_halt),
    .done(done), .err(err), .run_cycles(run_cycles)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  logic [31:0] sb_q[$];
  logic [8:0]  prog[0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // write monitor: every strobe must match the oldest expected {addr,data}
  always @(negedge CLK) begin
    if (err) err_cnt++;
    if (inst_wr_en === 1'b1) begin
      if (sb_q.size() == 0) chk("wr_unexp", {13'd0, inst_wr_addr, inst_wr_data}, 32'hFFFF_FFFF);
      else chk("wr", {13'd0, inst_wr_addr, inst_wr_data}, sb_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit jit);
    int n;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (jit) cpu_halt = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge CLK); #1; n++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input int n, input int gapmax, input bit jit);
    logic [15:0] nn;
    nn = 16'(n);
    send_byte(nn[7:0], 0, 1'b0);
    send_byte(nn[15:8], 0, 1'b0);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back((32'(i) << 9) | 32'(prog[i]));
      send_byte(prog[i][7:0], $urandom_range(0, gapmax), jit);
      send_byte({7'($urandom), prog[i][8]}, $urandom_range(0, gapmax), jit);
    end
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_start && n < 20) begin @(posedge CLK); #1; n++; end
    chk("run_entry", 32'(cpu_start), 32'd0);
  endtask

  task automatic run_and_halt(input int cyc, input string tag);
    repeat (cyc) @(posedge CLK);
    #1;
    chk({tag, "_done_pre"}, 32'(done), 32'd0);
    cpu_halt = 1'b1;
    @(posedge CLK); #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, 32'(run_cycles), 32'(cyc));
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    cpu_halt = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; cpu_halt = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en", 32'(inst_wr_en), 32'd0);
    chk("rst_start", 32'(cpu_start), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cycles", 32'(run_cycles), 32'd0);
    reset = 1'b0;

    // basic N=3 load and boot window
    prog[0] = 9'h012; prog[1] = 9'h134; prog[2] = 9'h0FF;
    load(3, 0, 1'b0);
    chk("boot0_start", 32'(cpu_start), 32'd1);
    chk("boot0_ready", 32'(in_ready), 32'd0);
    @(posedge CLK); #1;
    chk("boot1_start", 32'(cpu_start), 32'd1);
    @(posedge CLK); #1;
    chk("boot2_start", 32'(cpu_start), 32'd0);
    chk("run_ready", 32'(in_ready), 32'd0);
    run_and_halt(37, "run37");
    @(posedge CLK); #1;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_cycles_hold", 32'(run_cycles), 32'd37);

    // new session straight from DONE
    prog[0] = 9'h1A5; prog[1] = 9'h077;
    send_byte(8'h02, 0, 1'b0);
    chk("sess_done_clr", 32'(done), 32'd0);
    chk("sess_start", 32'(cpu_start), 32'd1);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back((32'(i) << 9) | 32'(prog[i]));
      send_byte(prog[i][7:0], 0, 1'b0);
      send_byte({7'd0, prog[i][8]}, 0, 1'b0);
    end
    wait_run();
    run_and_halt(5, "run5");

    // malformed headers
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    chk("err0_pulse", 32'(err), 32'd1);
    chk("err0_start", 32'(cpu_start), 32'd1);
    @(posedge CLK); #1;
    chk("err0_clr", 32'(err), 32'd0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    chk("err1_pulse", 32'(err), 32'd1);
    @(posedge CLK); #1;
    chk("err1_clr", 32'(err), 32'd0);
    chk("err_start", 32'(cpu_start), 32'd1);
    chk("err_ready", 32'(in_ready), 32'd1);
    chk("err_count", 32'(err_cnt), 32'd2);

    // gapped host, halt toggling during load and BOOT
    prog[0] = 9'h101; prog[1] = 9'h0AA; prog[2] = 9'h155; prog[3] = 9'h1FE;
    load(4, 3, 1'b1);
    cpu_halt = 1'b1;
    @(posedge CLK); #1;
    chk("jit_boot_start", 32'(cpu_start), 32'd1);
    cpu_halt = 1'b0;
    wait_run();
    run_and_halt(10, "run10");

    // reset while waiting for the high byte of word 2
    prog[0] = 9'h003; prog[1] = 9'h1C0;
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back((32'(i) << 9) | 32'(prog[i]));
      send_byte(prog[i][7:0], 0, 1'b0);
      send_byte({7'd0, prog[i][8]}, 0, 1'b0);
    end
    send_byte(8'h5A, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_start", 32'(cpu_start), 32'd1);
    chk("arst_wr_en", 32'(inst_wr_en), 32'd0);
    chk("arst_addr", 32'(inst_wr_addr), 32'd0);
    chk("arst_data", 32'(inst_wr_data), 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;
    prog[0] = 9'h155;
    load(1, 0, 1'b0);
    wait_run();

    // saturation
    repeat (70000) @(posedge CLK);
    #1;
    chk("sat_done_pre", 32'(done), 32'd0);
    chk("sat_cycles", 32'(run_cycles), 32'hFFFF);
    cpu_halt = 1'b1;
    @(posedge CLK); #1;
    chk("sat_done", 32'(done), 32'd1);
    chk("sat_hold", 32'(run_cycles), 32'hFFFF);
    cpu_halt = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
